// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed program image one byte at a time,
// assembles little-endian 32-bit words and writes them to instruction memory.
// The CPU core is held in reset until the whole image has been written.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match all payload bytes before the load is declared done.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_WIDTH);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
`endif

  state_t                r_state;
  state_t                w_state_next;
  logic [15:0]           r_len;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_buf;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;
  logic [ADDR_WIDTH:0]   r_word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_rx_ready;
  logic                  w_done;
  logic                  w_error;
  logic                  w_cpu_rst;
  logic                  w_accept;
  logic [15:0]           w_len_full;
  logic                  w_len_bad;
  logic                  w_last_word;
  logic [ADDR_WIDTH:0]   w_count_inc;

  assign w_accept    = rx_valid && w_rx_ready;
  // Length as it will be once the high byte currently on rx_data is taken.
  assign w_len_full  = {rx_data, r_len[7:0]};
  assign w_len_bad   = (w_len_full == 16'd0) || ({16'b0, w_len_full} > MAX_WORDS);
  assign w_count_inc = r_word_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
  // The word being completed now is the final one of the frame.
  assign w_last_word = ({16'b0, r_len} == 32'(w_count_inc));

  // State register; reset has priority over any byte arriving on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) r_state <= LEN_LO;
    else     r_state <= w_state_next;
  end

  // Next-state decode and per-state status outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_rx_ready   = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;
    w_cpu_rst    = 1'b1;
    case (r_state)
      LEN_LO: begin
        w_rx_ready = 1'b1;
        if (rx_valid) w_state_next = LEN_HI;
      end
      LEN_HI: begin
        w_rx_ready = 1'b1;
        if (rx_valid) w_state_next = w_len_bad ? ERR : DATA;
      end
      DATA: begin
        w_rx_ready = 1'b1;
        if (rx_valid && (r_byte_idx == 2'd3) && w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_next = CHECK;
`else
          w_state_next = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        w_rx_ready = 1'b1;
        if (rx_valid) w_state_next = (rx_data == r_csum) ? DONE : ERR;
      end
`endif
      DONE: begin
        w_done    = 1'b1;
        w_cpu_rst = 1'b0;
      end
      ERR: begin
        w_error = 1'b1;
      end
      default: w_state_next = LEN_LO;
    endcase
  end

  // Datapath: length capture, byte assembly, write strobe and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len        <= '0;
      r_byte_idx   <= '0;
      r_buf        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept) begin
        case (r_state)
          LEN_LO: r_len[7:0]  <= rx_data;
          LEN_HI: r_len[15:8] <= rx_data;
          DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ rx_data;
`endif
            case (r_byte_idx)
              2'd0: r_buf[7:0]   <= rx_data;
              2'd1: r_buf[15:8]  <= rx_data;
              2'd2: r_buf[23:16] <= rx_data;
              default: begin
                // Address is the count before this word; count and strobe
                // become visible together on the next cycle.
                r_wr_en      <= 1'b1;
                r_wr_addr    <= r_word_count[ADDR_WIDTH-1:0];
                r_wr_data    <= {rx_data, r_buf};
                r_word_count <= w_count_inc;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready   = w_rx_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign word_count = r_word_count;
  assign cpu_rst    = w_cpu_rst;
  assign done       = w_done;
  assign error      = w_error;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a table of per-cycle vectors with hand-computed
// expected outputs, plus hand-written multi-cycle sequences (stall pattern,
// and the checksum frame when LOADER_CHECKSUM_EN is defined).
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_rst;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  typedef struct {
    logic          rst;
    logic          valid;
    logic [7:0]    data;
    logic          e_ready;
    logic          e_wr_en;
    logic          e_done;
    logic          e_error;
    logic          e_cpu_rst;
    logic [AW:0]   e_wc;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;
  } vec_t;

  vec_t vecs[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Writes observed after each step.
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  logic          log_done[$];
  logic [AW:0]   log_wc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic vl, input logic [7:0] d);
    rst      = r;
    rx_valid = vl;
    rx_data  = d;
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_done.push_back(done);
      log_wc.push_back(word_count);
    end
  endtask

  task automatic add(input logic r, input logic vl, input logic [7:0] d,
                     input logic rdy, input logic we, input logic dn, input logic er,
                     input logic cr, input logic [AW:0] wc, input logic [AW-1:0] ad,
                     input logic [31:0] wd);
    vec_t v;
    v.rst = r; v.valid = vl; v.data = d;
    v.e_ready = rdy; v.e_wr_en = we; v.e_done = dn; v.e_error = er;
    v.e_cpu_rst = cr; v.e_wc = wc; v.e_addr = ad; v.e_wdata = wd;
    vecs.push_back(v);
  endtask

  // Expected outputs in the idle/collecting state right after reset.
  task automatic add_r(input logic r, input logic vl, input logic [7:0] d);
    add(r, vl, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h0);
  endtask

  task automatic add_err(input logic vl, input logic [7:0] d);
    add(1'b0, vl, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 32'h0);
  endtask

  initial begin
    logic [7:0] gap_bytes[10];
    logic [63:0] act;
    logic [63:0] exp;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

`ifndef LOADER_CHECKSUM_EN
    // Single-word frame 01 00 13 05 A0 00 with a one-cycle stall.
    add_r(1, 0, 8'h00);
    add_r(0, 1, 8'h01);
    add_r(0, 1, 8'h00);
    add_r(0, 1, 8'h13);
    add_r(0, 0, 8'h77);
    add_r(0, 1, 8'h05);
    add_r(0, 1, 8'hA0);
    add(0, 1, 8'h00, 0, 1, 1, 0, 0, 9'd1, 8'd0, 32'h00A00513);
    // Eight bytes offered after done: all ignored, outputs frozen.
    for (int i = 0; i < 8; i++)
      add(0, 1, 8'hF0 + 8'(i), 0, 0, 1, 0, 0, 9'd1, 8'd0, 32'h00A00513);
    // Reset wins over a simultaneous byte; then zero length -> error.
    add_r(1, 1, 8'h55);
    add_r(0, 1, 8'h00);
    add_err(1, 8'h00);
    add_err(1, 8'hAA);
    // Reset after two payload bytes, then a fresh single-word frame.
    add_r(1, 0, 8'h00);
    add_r(0, 1, 8'h01);
    add_r(0, 1, 8'h00);
    add_r(0, 1, 8'hDE);
    add_r(0, 1, 8'hAD);
    add_r(1, 1, 8'hBE);
    add_r(0, 1, 8'h01);
    add_r(0, 1, 8'h00);
    add_r(0, 1, 8'hEF);
    add_r(0, 0, 8'h99);
    add_r(0, 1, 8'hBE);
    add_r(0, 1, 8'hAD);
    add(0, 1, 8'hDE, 0, 1, 1, 0, 0, 9'd1, 8'd0, 32'hDEADBEEF);
    // Length 257 exceeds 2**8 words -> error.
    add_r(1, 0, 8'h00);
    add_r(0, 1, 8'h01);
    add_err(1, 8'h01);
    // Length 256 is the largest legal frame -> keeps collecting.
    add_r(1, 0, 8'h00);
    add_r(0, 1, 8'h00);
    add_r(0, 1, 8'h01);
    add_r(1, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].data);
      act = 64'({rx_ready, wr_en, done, error, cpu_rst, word_count, wr_addr, wr_data});
      exp = 64'({vecs[i].e_ready, vecs[i].e_wr_en, vecs[i].e_done, vecs[i].e_error,
                 vecs[i].e_cpu_rst, vecs[i].e_wc, vecs[i].e_addr, vecs[i].e_wdata});
      check($sformatf("vec[%0d]", i), act, exp);
    end

    // N = 2, valid toggling every other cycle, 5-cycle gap inside word 0.
    log_addr.delete(); log_data.delete(); log_done.delete(); log_wc.delete();
    gap_bytes = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h89};
    step(1, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, gap_bytes[i]);
      step(0, 0, 8'hFF);
      if (i == 3) for (int g = 0; g < 5; g++) step(0, 0, 8'h5A);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 8'h66);
    check("gap write count", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() >= 2) begin
      check("gap addr0", 64'(log_addr[0]), 64'd0);
      check("gap data0", 64'(log_data[0]), 64'h12345678);
      check("gap done at write0", 64'(log_done[0]), 64'd0);
      check("gap wc at write0", 64'(log_wc[0]), 64'd1);
      check("gap addr1", 64'(log_addr[1]), 64'd1);
      check("gap data1", 64'(log_data[1]), 64'h89ABCDEF);
      check("gap done at write1", 64'(log_done[1]), 64'd1);
      check("gap wc at write1", 64'(log_wc[1]), 64'd2);
    end
    check("gap final word_count", 64'(word_count), 64'd2);
    check("gap final done/cpu_rst/ready", 64'({done, cpu_rst, rx_ready}), 64'b100);
`else
    // Checksum: 11^22^33^44 = 44.
    for (int pass = 0; pass < 2; pass++) begin
      log_addr.delete(); log_data.delete(); log_done.delete(); log_wc.delete();
      step(1, 0, 8'h00);
      check($sformatf("csum%0d reset", pass), 64'({rx_ready, cpu_rst, done, error}), 64'b1100);
      step(0, 1, 8'h01);
      step(0, 1, 8'h00);
      step(0, 1, 8'h11);
      step(0, 1, 8'h22);
      step(0, 1, 8'h33);
      step(0, 1, 8'h44);
      check($sformatf("csum%0d write", pass), 64'({wr_en, wr_addr, wr_data}),
            64'({1'b1, 8'd0, 32'h44332211}));
      check($sformatf("csum%0d waiting", pass), 64'({rx_ready, cpu_rst, done, error}), 64'b1100);
      step(0, 1, (pass == 0) ? 8'h44 : 8'h45);
      if (pass == 0)
        check("csum good end", 64'({rx_ready, cpu_rst, done, error, wr_en}), 64'b00100);
      else
        check("csum bad end", 64'({rx_ready, cpu_rst, done, error, wr_en}), 64'b01010);
      step(0, 1, 8'h44);
      check($sformatf("csum%0d terminal", pass), 64'({done, error, word_count}),
            (pass == 0) ? 64'({2'b10, 9'd1}) : 64'({2'b01, 9'd1}));
      check($sformatf("csum%0d writes", pass), 64'(log_addr.size()), 64'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL be the instruction-memory word-address width; MAX_WORDS = 2**ADDR_WIDTH.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 rx_data  input  8  SHALL carry the incoming program byte.
REQ-005 rx_valid  input  1  SHALL flag rx_data valid; a byte is accepted on an edge where rx_valid && rx_ready.
REQ-006 rx_ready  output  1  SHALL flag the loader able to accept a byte.
REQ-007 wr_en  output  1  SHALL be the one-cycle instruction-memory write strobe.
REQ-008 wr_addr  output  ADDR_WIDTH  SHALL be the word address of the write.
REQ-009 wr_data  output  32  SHALL be the assembled instruction word.
REQ-010 cpu_rst  output  1  SHALL hold the CPU core in reset while the load is incomplete.
REQ-011 done  output  1  SHALL flag a successful load.
REQ-012 error  output  1  SHALL flag a failed load.
REQ-013 word_count  output  ADDR_WIDTH+1  SHALL give the number of words written so far.

Function
REQ-014 Frame format SHALL be: length N as 2 bytes little-endian (words), then 4N payload bytes, each word little-endian (first byte = bits 7:0), then the optional checksum byte (REQ-030).
REQ-015 FSM states SHALL be LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
REQ-016 LEN_LO: accepted byte -> len[7:0], go LEN_HI.
REQ-017 LEN_HI: accepted byte -> len[15:8]; if N == 0 or N > MAX_WORDS go ERR, else go DATA.
REQ-018 DATA: 2-bit byte counter SHALL wrap 3->0; on acceptance of byte index 3, the full word SHALL appear on wr_data with wr_en = 1 for exactly the following cycle, wr_addr = words written before it (first word at 0).
REQ-019 word_count SHALL increment in the same cycle wr_en is high; it never exceeds N.
REQ-020 On acceptance of the last byte of word N-1, FSM SHALL go CHECK (macro defined) or DONE (macro undefined).
REQ-021 rx_ready SHALL be 1 in LEN_LO, LEN_HI, DATA, CHECK and 0 in DONE, ERR.
REQ-022 rx_valid low in any state SHALL leave all state unchanged (stalls of any length legal; partial word retained).
REQ-023 Bytes presented in DONE or ERR SHALL be ignored.
REQ-024 cpu_rst SHALL be 1 in every state except DONE; done = 1 only in DONE; error = 1 only in ERR.
REQ-025 DONE and ERR SHALL be terminal until rst.
REQ-026 The final wr_en pulse and the first done = 1 cycle SHALL coincide (macro undefined); no write is issued after done rises.

Reset
REQ-027 rst = 1 SHALL, at the next edge, force state LEN_LO, rx_ready = 1 after release, wr_en = 0, wr_addr = 0, wr_data = 0, word_count = 0, done = 0, error = 0, cpu_rst = 1, checksum accumulator = 0.
REQ-028 rst asserted mid-frame SHALL discard the partial word and count; previously written memory words are not erased.
REQ-029 rst has priority over a simultaneous byte acceptance.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, the loader SHALL XOR all 4N payload bytes into an 8-bit accumulator; in CHECK, one accepted byte equal to the accumulator -> DONE, unequal -> ERR.
REQ-031 Without LOADER_CHECKSUM_EN, CHECK and the accumulator SHALL not exist and the frame ends after the last payload byte.

Verification
REQ-032 Bytes 01 00 13 05 A0 00 (no macro) -> one wr_en, wr_addr 0, wr_data 0x00A00513; done = 1 and cpu_rst = 0 on same cycle as the write; word_count 1.
REQ-033 Length bytes 00 00 -> error = 1, rx_ready = 0, no wr_en ever; with ADDR_WIDTH 8, length 01 01 (257) -> error = 1.
REQ-034 N = 2, rx_valid toggled every other cycle with 5-cycle gap inside word 0 -> writes at addr 0 then 1 with correct words; no extra or missing strobes.
REQ-035 Macro defined, N = 1, payload 11 22 33 44, checksum 44 -> done = 1; same with checksum 45 -> error = 1, cpu_rst stays 1.
REQ-036 rst pulsed after 2 payload bytes, then full valid frame N = 1 -> single write at addr 0 with new word; word_count 1.
REQ-037 After done, 8 extra bytes presented -> rx_ready = 0, no wr_en, outputs unchanged.
